br_resolve: RTL

BR_RESOLVE -- requirements
Module: br_resolve

---
 rtl/br_pkg.sv | 34 +++
 rtl/br_resolve_if.sv | 42 ++++
 rtl/br_meta_stage.sv | 23 ++
 rtl/br_resolve.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and sizes for the branch-resolution slice: prediction metadata,
// recovery FSM states and the misprediction rule.
package br_pkg;

    localparam int unsigned GBIT = 10;
    localparam int unsigned CNTW = 16;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
        logic [GBIT-1:0] pattern;
    } pred_meta_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } br_state_e;

    // A false BTB hit on a non-control instruction is also a mispredict.
    function automatic logic mispredict(input logic is_br,
                                        input logic is_jmp,
                                        input logic pred_taken,
                                        input logic taken,
                                        input logic tgt_hit);
        return (is_br && (pred_taken != taken))
            || ((is_br || is_jmp) && pred_taken && !tgt_hit)
            || (is_jmp && !pred_taken)
            || (!is_br && !is_jmp && pred_taken);
    endfunction

endpackage

// File: rtl/br_resolve_if.sv
// Fetch prediction, execute outcome and resolution outputs of br_resolve.
interface br_resolve_if #(
    parameter int unsigned GBIT = br_pkg::GBIT,
    parameter int unsigned CNTW = br_pkg::CNTW
);
    logic                        i_stall;
    logic [br_pkg::XLEN-1:0]     i_pc_F;
    logic                        i_pred_taken_F;
    logic [br_pkg::XLEN-1:0]     i_pred_target_F;
    logic [GBIT-1:0]             i_pattern_F;
    logic [br_pkg::XLEN-1:0]     i_pc_E;
    logic                        i_branch_en_E;
    logic                        i_jump_en_E;
    logic                        i_taken_E;
    logic [br_pkg::XLEN-1:0]     i_target_E;
    logic                        o_redirect;
    logic [br_pkg::XLEN-1:0]     o_redirect_pc;
    logic                        o_flush_FD;
    logic                        o_upd_valid;
    logic [br_pkg::XLEN-1:0]     o_upd_pc;
    logic                        o_upd_taken;
    logic [br_pkg::XLEN-1:0]     o_upd_target;
    logic [GBIT-1:0]             o_upd_pattern;
    logic [CNTW-1:0]             o_branch_cnt;
    logic [CNTW-1:0]             o_mispred_cnt;

    modport slave (
        input  i_stall, i_pc_F, i_pred_taken_F, i_pred_target_F, i_pattern_F,
        input  i_pc_E, i_branch_en_E, i_jump_en_E, i_taken_E, i_target_E,
        output o_redirect, o_redirect_pc, o_flush_FD,
        output o_upd_valid, o_upd_pc, o_upd_taken, o_upd_target, o_upd_pattern,
        output o_branch_cnt, o_mispred_cnt
    );

    modport master (
        output i_stall, i_pc_F, i_pred_taken_F, i_pred_target_F, i_pattern_F,
        output i_pc_E, i_branch_en_E, i_jump_en_E, i_taken_E, i_target_E,
        input  o_redirect, o_redirect_pc, o_flush_FD,
        input  o_upd_valid, o_upd_pc, o_upd_taken, o_upd_target, o_upd_pattern,
        input  o_branch_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/br_meta_stage.sv
// One prediction-metadata pipeline register; flush wins over stall.
module br_meta_stage
    import br_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  pred_meta_t d,
    output pred_meta_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/br_resolve.sv
// Resolves execute-stage branches against the fetch-time prediction: redirects
// fetch on a mispredict, trains the predictor and keeps performance counters.
module br_resolve #(
    parameter int unsigned GBIT = br_pkg::GBIT,
    parameter int unsigned CNTW = br_pkg::CNTW
) (
    input logic         i_clk,
    input logic         i_rst_n,
    br_resolve_if.slave bus
);
    import br_pkg::*;

    localparam int unsigned PGBIT = br_pkg::GBIT;

    pred_meta_t meta_f, meta_d, meta_e;
    br_state_e  state_q, state_d;

    logic            flush_d_c, flush_e_c;
    logic            eval_c, is_br_c, is_jmp_c, mispred_c, taken_c;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            upd_valid_q, upd_valid_d;
    logic [XLEN-1:0] upd_pc_q, upd_pc_d;
    logic            upd_taken_q, upd_taken_d;
    logic [XLEN-1:0] upd_target_q, upd_target_d;
    logic [GBIT-1:0] upd_pattern_q, upd_pattern_d;
    logic [CNTW-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNTW-1:0] mispred_cnt_q, mispred_cnt_d;

    // Every fetch slot carries a prediction; wrong-path slots are killed by flushes.
    always_comb begin
        meta_f             = '0;
        meta_f.valid       = 1'b1;
        meta_f.pc          = bus.i_pc_F;
        meta_f.pred_taken  = bus.i_pred_taken_F;
        meta_f.pred_target = bus.i_pred_target_F;
        meta_f.pattern     = PGBIT'(bus.i_pattern_F);
    end

    br_meta_stage u_stage_fd (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .stall (bus.i_stall),
        .flush (flush_d_c),
        .d     (meta_f),
        .q     (meta_d)
    );

    br_meta_stage u_stage_de (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .stall (bus.i_stall),
        .flush (flush_e_c),
        .d     (meta_d),
        .q     (meta_e)
    );

    // Next state, evaluation and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        eval_c        = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        upd_target_d  = upd_target_q;
        upd_pattern_d = upd_pattern_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        is_jmp_c  = bus.i_jump_en_E;
        is_br_c   = bus.i_branch_en_E & ~bus.i_jump_en_E;
        taken_c   = is_jmp_c | (is_br_c & bus.i_taken_E);
        mispred_c = mispredict(is_br_c, is_jmp_c, meta_e.pred_taken, bus.i_taken_E,
                               meta_e.pred_target == bus.i_target_E);

        case (state_q)
            RUN: begin
                eval_c = meta_e.valid & ~bus.i_stall;
                if (eval_c && mispred_c) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase

        if (eval_c && mispred_c) begin
            redirect_d    = 1'b1;
            redirect_pc_d = taken_c ? bus.i_target_E : bus.i_pc_E + XLEN'(4);
            if (mispred_cnt_q != '1) begin
                mispred_cnt_d = mispred_cnt_q + CNTW'(1);
            end
        end

        if (eval_c && is_br_c) begin
            upd_valid_d   = 1'b1;
            upd_pc_d      = meta_e.pc;
            upd_taken_d   = bus.i_taken_E;
            upd_target_d  = bus.i_target_E;
            upd_pattern_d = GBIT'(meta_e.pattern);
        end

        if (eval_c && (is_br_c || is_jmp_c) && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + CNTW'(1);
        end

        // The fetch slot seen during RECOVER is still wrong-path, so D is flushed again.
        flush_e_c = redirect_d;
        flush_d_c = redirect_d | (state_q == RECOVER);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= RUN;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_target_q  <= '0;
            upd_pattern_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            upd_target_q  <= upd_target_d;
            upd_pattern_q <= upd_pattern_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bus.o_redirect    = redirect_q;
    assign bus.o_redirect_pc = redirect_pc_q;
    assign bus.o_flush_FD    = redirect_q;
    assign bus.o_upd_valid   = upd_valid_q;
    assign bus.o_upd_pc      = upd_pc_q;
    assign bus.o_upd_taken   = upd_taken_q;
    assign bus.o_upd_target  = upd_target_q;
    assign bus.o_upd_pattern = upd_pattern_q;
    assign bus.o_branch_cnt  = branch_cnt_q;
    assign bus.o_mispred_cnt = mispred_cnt_q;

endmodule
